mat_wb_loader: RTL and testbench

MAT_WB_LOADER -- requirements
Module: mat_wb_loader

---
 rtl/mat_wb_loader.sv | 162 ++++++++++++++++
 tb/tb_mat_wb_loader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_wb_loader.sv
// Wishbone master that streams two 3x3 byte matrices to a multiply slave
// and reads the product back; MAT_WB_TIMEOUT_EN adds an ack watchdog.
module mat_wb_loader #(
  parameter int A_BASE      = 0,
  parameter int B_BASE      = 9,
  parameter int C_BASE      = 18,
  parameter int N_ELEM      = 9,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [8*N_ELEM-1:0]   a_in,
  input  logic [8*N_ELEM-1:0]   b_in,
  output logic [8*N_ELEM-1:0]   c_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cyc,
  output logic                  stb,
  output logic                  we,
  output logic [3:0]            wb_sel,
  output logic [31:0]           adr,
  output logic [31:0]           dat_mosi,
  input  logic [31:0]           dat_miso,
  input  logic                  ack,
  input  logic                  err
);

  localparam int IW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_ELEM - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WR_A  = 3'd1;
  localparam logic [2:0] WR_B  = 3'd2;
  localparam logic [2:0] RD_C  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;
  localparam logic [2:0] FIN   = 3'd5;
  localparam logic [2:0] FAULT = 3'd6;

  logic [2:0]          st_q, st_d;
  logic [2:0]          ret_q, ret_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [8*N_ELEM-1:0] a_q, a_d;
  logic [8*N_ELEM-1:0] b_q, b_d;
  logic [8*N_ELEM-1:0] c_q, c_d;
  logic                err_q, err_d;
  logic                arm_q;
  logic                xfer;
  logic                tmo;
  logic [7:0]          elem;
  logic                unused_ok;

  assign unused_ok = ^{dat_miso[31:8], (TIMEOUT_CYC > 0)};

  assign xfer = (st_q == WR_A) || (st_q == WR_B) ||
                (st_q == RD_C);

`ifdef MAT_WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wd_q, wd_d;
  logic          stall;

  assign stall = xfer && !ack && !err;
  assign tmo   = stall && (wd_q == TW'(TIMEOUT_CYC - 1));
  assign wd_d  = stall ? wd_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    elem = (st_q == WR_A) ? a_q[{idx_q, 3'b000} +: 8]
                          : b_q[{idx_q, 3'b000} +: 8];
    cyc      = xfer;
    stb      = xfer;
    we       = (st_q == WR_A) || (st_q == WR_B);
    wb_sel   = we ? 4'b0001 : 4'b0000;
    dat_mosi = we ? {24'b0, elem} : 32'b0;
    adr      = 32'b0;
    unique case (1'b1)
      st_q == WR_A: adr = 32'(A_BASE) + 32'(idx_q);
      st_q == WR_B: adr = 32'(B_BASE) + 32'(idx_q);
      st_q == RD_C: adr = 32'(C_BASE) + 32'(idx_q);
      default:      adr = 32'b0;
    endcase
    busy  = (st_q != IDLE);
    done  = (st_q == FIN);
    error = err_q;
    c_out = c_q;
  end

  always_comb begin
    st_d  = st_q;
    ret_d = ret_q;
    idx_d = idx_q;
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    err_d = err_q;
    unique case (st_q)
      IDLE: begin
        // arm_q masks the first cycle out of reset
        if (start && arm_q) begin
          a_d   = a_in;
          b_d   = b_in;
          err_d = 1'b0;
          idx_d = '0;
          st_d  = WR_A;
        end
      end
      WR_A, WR_B, RD_C: begin
        if (err || tmo) begin
          err_d = 1'b1;
          st_d  = FAULT;
        end else if (ack) begin
          if (st_q == RD_C)
            c_d[{idx_q, 3'b000} +: 8] = dat_miso[7:0];
          st_d  = GAP;
          ret_d = st_q;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST) begin
            idx_d = '0;
            ret_d = (st_q == WR_A) ? WR_B :
                    (st_q == WR_B) ? RD_C : FIN;
          end
        end
      end
      GAP:     st_d = ret_q;
      FAULT:   st_d = FIN;
      FIN:     st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      ret_q <= IDLE;
      idx_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      err_q <= 1'b0;
      arm_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      ret_q <= ret_d;
      idx_q <= idx_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      err_q <= err_d;
      arm_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mat_wb_loader.sv
// Randomised bench for mat_wb_loader: matrix slave model plus a
// transfer-queue reference checked every cycle.
module tb_mat_wb_loader;

  localparam int A_BASE = 0;
  localparam int B_BASE = 9;
  localparam int C_BASE = 18;
  localparam int NE     = 9;
  localparam int TMO    = 255;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [71:0] a_in, b_in, c_out;
  logic        busy, done, error, cyc, stb, we;
  logic [3:0]  wb_sel;
  logic [31:0] adr, dat_mosi, dat_miso;
  logic        ack, err;

  mat_wb_loader #(
    .A_BASE(A_BASE), .B_BASE(B_BASE), .C_BASE(C_BASE),
    .N_ELEM(NE), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_in(a_in), .b_in(b_in), .c_out(c_out),
    .busy(busy), .done(done), .error(error),
    .cyc(cyc), .stb(stb), .we(we), .wb_sel(wb_sel),
    .adr(adr), .dat_mosi(dat_mosi), .dat_miso(dat_miso),
    .ack(ack), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [7:0]  dat;
  } xfer_t;

  xfer_t       expq[$];
  int          errs = 0, checks = 0;
  int          cy = 0;
  bit          job = 0, job_err = 0;
  int          start_cy = 0, done_at = 0, last_ack_cy = -10;
  bit          err_exp = 0, set_err_pend = 0, clr_err_pend = 0;
  bit          c_pend = 0;
  int          c_pk = 0;
  logic [7:0]  c_pv;
  logic [71:0] c_exp = '0, snap_a = '0, snap_b = '0;
  bit          rst_prev = 0;
  int          cnt = 0, wt = 0;
  logic [7:0]  mem [0:31];
  int          err_adr = -1, stall_adr = -1;
  bit          zero_wait = 1;
  int          n_xfer = 0, max_adr = 0;

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] matmul(input logic [71:0] a,
                                         input logic [71:0] b);
    logic [71:0] r = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        int s = 0;
        for (int k = 0; k < 3; k++)
          s += int'(a[8*(3*i+k) +: 8]) * int'(b[8*(3*k+j) +: 8]);
        r[8*(3*i+j) +: 8] = 8'(s);
      end
    return r;
  endfunction

  function automatic logic [7:0] cread(input int k);
    int s = 0;
    for (int j = 0; j < 3; j++)
      s += int'(mem[A_BASE + 3*(k/3) + j]) * int'(mem[B_BASE + 3*j + k%3]);
    return 8'(s);
  endfunction

  task automatic fault_model();
    expq.delete();
    done_at = cy + 2;
    last_ack_cy = cy;
    set_err_pend = 1;
    job_err = 1;
  endtask

  task automatic cycle_step();
    bit busy_e, done_e, cyc_e;
    int a;
    cy++;
    if (!rst_n) begin
      expq.delete();
      job = 0; err_exp = 0; c_exp = '0; rst_prev = 0;
      set_err_pend = 0; clr_err_pend = 0; c_pend = 0;
      cnt = 0; ack = 0; err = 0;
      chk("rst_ctl", 160'({cyc, stb, we, busy, done, error}), 0);
      chk("rst_bus", 160'({wb_sel, adr, dat_mosi}), 0);
      chk("rst_cout", 160'(c_out), 0);
      return;
    end
    if (clr_err_pend) err_exp = 0;
    if (set_err_pend) err_exp = 1;
    if (c_pend) c_exp[8*c_pk +: 8] = c_pv;
    clr_err_pend = 0; set_err_pend = 0; c_pend = 0;

    busy_e = job && cy > start_cy && cy <= done_at;
    done_e = job && cy == done_at;
    cyc_e  = job && cy > start_cy && expq.size() > 0 &&
             cy != last_ack_cy + 1;
    chk("busy", 160'(busy), 160'(busy_e));
    chk("done", 160'(done), 160'(done_e));
    chk("error", 160'(error), 160'(err_exp));
    chk("c_out", 160'(c_out), 160'(c_exp));
    chk("cyc", 160'(cyc), 160'(cyc_e));
    chk("stb", 160'(stb), 160'(cyc_e));
    if (cyc_e && cyc) begin
      chk("we", 160'(we), 160'(expq[0].we));
      chk("adr", 160'(adr), 160'(expq[0].adr));
      chk("sel", 160'(wb_sel), expq[0].we ? 160'(1) : 160'(0));
      chk("dat", 160'(dat_mosi),
          expq[0].we ? 160'(expq[0].dat) : 160'(0));
    end
    if (done_e) begin
      if (!job_err)
        chk("cout_matmul", 160'(c_out), 160'(matmul(snap_a, snap_b)));
      job = 0;
    end

    ack = 0; err = 0; dat_miso = $urandom;
    if (cyc && stb) begin
      cnt++;
      a = int'(adr);
      if (cnt == 1)
        wt = zero_wait ? 0 : int'($urandom_range(0, 3)) +
             ((a >= C_BASE) ? int'($urandom_range(0, 4)) : 0);
      if (a == stall_adr) begin
`ifdef MAT_WB_TIMEOUT_EN
        if (cnt == TMO) fault_model();
`endif
      end else if (cnt >= 2 + wt) begin
        n_xfer++;
        if (a > max_adr) max_adr = a;
        if (a == err_adr) begin
          err = 1;
          ack = 1'($urandom_range(0, 1));
          fault_model();
        end else begin
          ack = 1;
          if (we) mem[a] = dat_mosi[7:0];
          else begin
            dat_miso[7:0] = cread(a - C_BASE);
            c_pend = 1; c_pk = a - C_BASE; c_pv = dat_miso[7:0];
          end
          last_ack_cy = cy;
          if (expq.size() > 0) begin
            void'(expq.pop_front());
            if (expq.size() == 0) done_at = cy + 2;
          end
        end
      end
    end else cnt = 0;

    if (start && rst_prev && !busy_e) begin
      snap_a = a_in; snap_b = b_in;
      expq.delete();
      for (int k = 0; k < NE; k++)
        expq.push_back({1'b1, 32'(A_BASE + k), a_in[8*k +: 8]});
      for (int k = 0; k < NE; k++)
        expq.push_back({1'b1, 32'(B_BASE + k), b_in[8*k +: 8]});
      for (int k = 0; k < NE; k++)
        expq.push_back({1'b0, 32'(C_BASE + k), 8'h00});
      job = 1; job_err = 0; start_cy = cy;
      done_at = 32'h7fffffff; last_ack_cy = -10;
      clr_err_pend = 1;
    end
    rst_prev = 1;
  endtask

  initial begin
    ack = 0; err = 0; dat_miso = '0;
    forever begin
      @(negedge clk);
      cycle_step();
    end
  end

  function automatic logic [71:0] rnd72();
    return {8'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  task automatic run_job(input logic [71:0] a, input logic [71:0] b,
                         input int extra, output int lat, output int nd);
    @(posedge clk); #2;
    a_in = a; b_in = b; start = 1;
    lat = 0; nd = 0;
    for (int i = 1; i <= 3000; i++) begin
      @(posedge clk); #2;
      start = (i == extra);
      if (i == extra) begin a_in = rnd72(); b_in = rnd72(); end
      if (done) begin
        nd++;
        if (lat == 0) lat = i;
      end
      if (lat != 0 && i >= lat + 4) break;
    end
    chk("done_once", 160'(nd), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
  endtask

  initial begin
    int lat, nd, found;
    logic [71:0] ra, rb;
    rst_n = 0; start = 0; a_in = '0; b_in = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    #2 rst_n = 1; start = 1;
    a_in = rnd72(); b_in = rnd72();
    @(posedge clk); #2 start = 0;
    repeat (3) @(posedge clk);
    #2 chk("start_after_rst_ignored", 160'(busy), 0);

    n_xfer = 0; max_adr = 0;
    run_job(72'h01_00_00_00_01_00_00_00_01,
            72'h09_08_07_06_05_04_03_02_01, 0, lat, nd);
    chk("identity_latency", 160'(lat), 82);
    chk("identity_cout", 160'(c_out), 160'(72'h09_08_07_06_05_04_03_02_01));
    chk("identity_xfers", 160'(n_xfer), 27);
    chk("identity_maxadr", 160'(max_adr), 26);
    chk("identity_error", 160'(error), 0);

    ra = rnd72(); rb = rnd72();
    n_xfer = 0;
    run_job(ra, rb, 20, lat, nd);
    chk("busy_start_xfers", 160'(n_xfer), 27);
    chk("busy_start_cout", 160'(c_out), 160'(matmul(ra, rb)));

    err_adr = 12; n_xfer = 0; max_adr = 0;
    run_job(rnd72(), rnd72(), 0, lat, nd);
    chk("err_flag", 160'(error), 1);
    chk("err_xfers", 160'(n_xfer), 13);
    chk("err_maxadr", 160'(max_adr), 12);
    repeat (4) @(posedge clk);
    #2 chk("err_cyc_low", 160'(cyc), 0);
    err_adr = -1;

    zero_wait = 0;
    @(posedge clk); #2;
    a_in = rnd72(); b_in = rnd72(); start = 1;
    @(posedge clk); #2 start = 0;
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (cyc && adr == 32'd20) begin found = 1; break; end
    end
    chk("adr20_seen", 160'(found), 1);
    #1 rst_n = 0;
    #1 chk("rst_async_bus", 160'({cyc, stb, we, wb_sel, adr}), 0);
    chk("rst_async_out", 160'({busy, done, error, c_out}), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    ra = rnd72(); rb = rnd72(); n_xfer = 0;
    run_job(ra, rb, 0, lat, nd);
    chk("post_rst_cout", 160'(c_out), 160'(matmul(ra, rb)));
    chk("post_rst_xfers", 160'(n_xfer), 27);

    for (int j = 0; j < 6; j++) begin
      ra = rnd72(); rb = rnd72();
      if (j == 2) begin ra = '1; rb = '1; end
      run_job(ra, rb, int'($urandom_range(0, 60)), lat, nd);
      chk("rand_cout", 160'(c_out), 160'(matmul(ra, rb)));
      chk("rand_error", 160'(error), 0);
    end

    stall_adr = 18; n_xfer = 0;
`ifdef MAT_WB_TIMEOUT_EN
    run_job(rnd72(), rnd72(), 0, lat, nd);
    chk("tmo_error", 160'(error), 1);
    chk("tmo_busy", 160'(busy), 0);
`else
    @(posedge clk); #2;
    a_in = rnd72(); b_in = rnd72(); start = 1;
    @(posedge clk); #2 start = 0;
    repeat (400) @(posedge clk);
    #2 chk("stall_busy", 160'(busy), 1);
    chk("stall_error", 160'(error), 0);
    chk("stall_xfers", 160'(n_xfer), 18);
`endif
    stall_adr = -1;
    do_reset();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
